cflog_rx_assembler: RTL

- Receive side of the byte-serial CFLog link.
- Accepts a stream of byte strobes from a UART receiver and reassembles them into 16-bit log entries, low byte first.
- Writes each entry into a word-addressed log buffer and reports frame completion or error.
- Sits between the UART RX and the verifier-side log memory; it is the counterpart of the on-device byte-serializing transmitter.

---
 rtl/cflog_link_pkg.sv | 25 ++
 rtl/rx_gap_timer.sv | 26 ++
 rtl/cflog_rx_assembler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cflog_link_pkg.sv
// Shared definitions for the byte-serial CFLog link (receiver and transmitter sides).
package cflog_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    DONE,
    ERR
  } rx_state_t;

  localparam logic [15:0] DEF_MAX_WORDS = 16'd1024;
  localparam logic [19:0] DEF_GAP_LIMIT = 20'h3FFFF;

  // Every multi-byte field on the link travels low byte first.
  localparam bit LO_FIRST = 1'b1;

  function automatic logic [15:0] packWord(input logic [7:0] firstByte,
                                           input logic [7:0] secondByte);
    return LO_FIRST ? {secondByte, firstByte} : {firstByte, secondByte};
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Saturating idle-cycle counter; flags expiry once the count reaches LIMIT.
module rx_gap_timer #(
  parameter logic [19:0] LIMIT = 20'h3FFFF
) (
  input  logic mclk,
  input  logic puc_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [19:0] r_count;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_count <= 20'd0;
    end else if (i_clear) begin
      r_count <= 20'd0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 20'd1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/cflog_rx_assembler.sv
// Reassembles CFLog byte strobes into length-prefixed frames of 16-bit words
// and streams each data word into a word-addressed log buffer.
module cflog_rx_assembler
  import cflog_link_pkg::*;
#(
  parameter logic [15:0] MAX_WORDS = DEF_MAX_WORDS,
  parameter logic [19:0] GAP_LIMIT = DEF_GAP_LIMIT
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        arm,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        wr_en,
  output logic [15:0] wr_idx,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_rcvd
);

  rx_state_t   r_state;
  rx_state_t   w_next;
  logic [7:0]  r_lo;
  logic [15:0] r_len;
  logic [15:0] r_words;
  logic        r_wrEn;
  logic [15:0] r_wrIdx;
  logic [15:0] r_wrData;
  logic        r_done;
  logic        w_active;
  logic        w_full;
  logic        w_accept;
  logic        w_write;
  logic        w_expired;
  logic [15:0] w_rxWord;

  // The cycle after the final write is spent in DATA_LO with the frame full,
  // so done lands one cycle behind the last wr_en; bytes there are dropped.
  assign w_active = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                    (r_state == DATA_LO) || (r_state == DATA_HI);
  assign w_full   = (r_state == DATA_LO) && (r_words == r_len);
  assign w_accept = rx_valid && !arm && w_active && !w_full;
  assign w_rxWord = packWord(r_lo, rx_byte);

  rx_gap_timer #(.LIMIT(GAP_LIMIT)) u_gapTimer (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .i_clear   (arm || w_accept),
    .i_enable  (w_active),
    .o_expired (w_expired)
  );

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    if (arm) begin
      w_next = LEN_LO;
    end else begin
      case (r_state)
        LEN_LO: begin
          if (w_accept)       w_next = LEN_HI;
          else if (w_expired) w_next = ERR;
        end
        LEN_HI: begin
          if (w_accept) begin
            if (w_rxWord == 16'd0)           w_next = DONE;
            else if (w_rxWord > MAX_WORDS)   w_next = ERR;
            else                             w_next = DATA_LO;
          end else if (w_expired) begin
            w_next = ERR;
          end
        end
        DATA_LO: begin
          if (w_full)         w_next = DONE;
          else if (w_accept)  w_next = DATA_HI;
          else if (w_expired) w_next = ERR;
        end
        DATA_HI: begin
          if (w_accept) begin
            w_next  = DATA_LO;
            w_write = 1'b1;
          end else if (w_expired) begin
            w_next = ERR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_lo     <= 8'd0;
      r_len    <= 16'd0;
      r_words  <= 16'd0;
      r_wrEn   <= 1'b0;
      r_wrIdx  <= 16'd0;
      r_wrData <= 16'd0;
      r_done   <= 1'b0;
    end else begin
      r_wrEn <= w_write;
      r_done <= (w_next == DONE) && (r_state != DONE);
      if (arm) begin
        r_words <= 16'd0;
      end else if (w_write) begin
        r_words  <= r_words + 16'd1;
        r_wrIdx  <= r_words;
        r_wrData <= w_rxWord;
      end
      if (w_accept && ((r_state == LEN_LO) || (r_state == DATA_LO))) begin
        r_lo <= rx_byte;
      end
      if (w_accept && (r_state == LEN_HI)) begin
        r_len <= w_rxWord;
      end
    end
  end

  assign wr_en      = r_wrEn;
  assign wr_idx     = r_wrIdx;
  assign wr_data    = r_wrData;
  assign busy       = w_active;
  assign done       = r_done;
  assign err        = (r_state == ERR);
  assign words_rcvd = r_words;

endmodule
